config_access_sync: RTL and testbench
=====================================

# config_access_sync

Parametrised successor to the fabric's config-bit export primitive. It takes NoConfigBits static configuration bits from the configuration SRAM, which are asynchronous to the user clock. It exports them to the fabric top as a synchronised, debounced, atomically committed vector. It adds a commit-hold input, a change pulse, and an LSB-first serial readback port so user logic can read back the committed configuration.

## Interface
- NoConfigBits, 8, width of config vector (1..64)
- SyncStages, 2, synchroniser flops per bit (>=2)
- StableCycles, 4, cycles the synchronised vector must stay unchanged before commit (1..255)
- ResetValue, 0, value of C_bits and all synchroniser/sample registers after reset
- One clock; reset is synchronous and active-high.
- UserCLK  in  1  fabric user clock; all state on rising edge
- Reset  in  1  synchronous, active-high reset
- ConfigBits  in  NoConfigBits  config SRAM bits (GLOBAL), asynchronous to UserCLK
- C_hold  in  1  while high, commits are deferred
- RB_start  in  1  single-cycle request to start a serial readback
- C_bits  out  NoConfigBits  committed config vector (EXTERNAL)
- C_changed  out  1  one-cycle pulse on every commit
- RB_valid  out  1  high while RB_data carries a readback bit
- RB_data  out  1  readback bit, LSB first
- RB_done  out  1  one-cycle pulse after the last readback bit

## Operation
- Synchroniser: SyncStages-deep flop chain per bit. Its output is s.
- Sample register s_q <= s every cycle.
- Stability counter cnt, saturating at StableCycles:
  - If s != s_q: cnt <= 0.
  - Otherwise cnt increments, saturating at StableCycles.
- Commit condition: cnt == StableCycles && s_q != C_bits && !C_hold.
  - On commit: C_bits <= s_q for the whole vector atomically, and C_changed <= 1.
  - On any other cycle: C_changed <= 0.
- No partial or per-bit commits. No commit when s_q == C_bits, so no pulse.
- Hold: commits are suppressed while C_hold is high; cnt keeps running. When C_hold falls and the condition holds, the commit happens on the next edge.
- Readback FSM, states IDLE and SHIFT:
  - IDLE + RB_start: snapshot C_bits into shift register sh, bit counter i <= 0, go to SHIFT.
  - SHIFT: RB_valid=1, RB_data=sh[0]. Each edge shifts sh right and increments i.
  - When i == NoConfigBits-1, the next edge returns to IDLE and pulses RB_done.
- RB_start in SHIFT is ignored, not queued.
- A commit during SHIFT does not alter the stream (snapshot semantics).
- RB_start on the same edge as a commit: the snapshot holds the pre-commit C_bits.
- Reset values:
  - C_bits = ResetValue; synchroniser and s_q = ResetValue; cnt = 0.
  - C_changed = 0; FSM = IDLE; RB_valid = RB_data = RB_done = 0.
- Reset wins over every other event. Reset mid-readback aborts the stream with no RB_done. Reset mid-stability discards the pending value.

## Timing
- ConfigBits change set up before edge E0 (the first sampling edge): C_bits updates after edge E0+SyncStages+StableCycles+1. Default: 7 edges.
- C_changed is high during the cycle immediately following the commit edge, exactly one cycle.
- Any change of s restarts the full StableCycles window, so a bit toggling with period <= StableCycles never commits.
- RB_start sampled at edge R:
  - RB_valid is high for cycles R+1..R+NoConfigBits.
  - RB_data in cycle R+1+k is bit k.
  - RB_done is high in cycle R+NoConfigBits+1.
- The earliest accepted next RB_start is the edge that begins the RB_done cycle's successor, i.e. the FSM is IDLE again in the RB_done cycle.
- Counters: cnt width clog2(StableCycles+1); i width clog2(NoConfigBits), minimum 1.

## Test plan
- Reset with ConfigBits=0x00, ResetValue=0: C_bits=0x00, C_changed=0, RB_valid=0 for 10 cycles, no pulse.
- ConfigBits 0x00→0xA5 held: C_bits stays 0x00 through edge 6 and becomes 0xA5 after edge 7. C_changed is a single 1-cycle pulse; no further pulses over 50 cycles.
- ConfigBits pulses to 0x01 for 3 cycles, then returns to 0x00, repeated 10 times: C_bits stays 0x00, C_changed never asserts.
- C_hold=1, ConfigBits→0x3C for 20 cycles: C_bits stays 0x00. Drop C_hold: C_bits=0x3C after the next edge, one C_changed pulse.
- C_bits=0xA5, RB_start 1 cycle:
  - RB_data over the 8 RB_valid cycles is 1,0,1,0,0,1,0,1, followed by an RB_done pulse.
  - A second RB_start in the 3rd valid cycle is ignored.
  - A commit to 0x3C mid-stream leaves the remaining bits unchanged.
- Reset asserted in the 4th readback cycle and mid stability window: next cycle RB_valid=0, RB_done never pulses, cnt=0, C_bits=ResetValue. A held ConfigBits value recommits 7 edges after reset release.

Source files
------------

// File: rtl/config_access_sync.sv
// Config-bit export: synchronises asynchronous configuration SRAM bits into the user clock
// domain, debounces them and commits the whole vector atomically. Adds a commit hold, a
// change pulse and an LSB-first serial readback of the committed vector.
module config_access_sync #(
  parameter int unsigned NoConfigBits = 8,
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned StableCycles = 4,
  parameter logic [NoConfigBits-1:0] ResetValue = '0
) (
  input  logic                    UserCLK,
  input  logic                    Reset,
  input  logic [NoConfigBits-1:0] ConfigBits,
  input  logic                    C_hold,
  input  logic                    RB_start,
  output logic [NoConfigBits-1:0] C_bits,
  output logic                    C_changed,
  output logic                    RB_valid,
  output logic                    RB_data,
  output logic                    RB_done
);

  localparam int unsigned CntW = $clog2(StableCycles + 1);
  localparam int unsigned IdxW = (NoConfigBits > 1) ? $clog2(NoConfigBits) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(StableCycles);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NoConfigBits - 1);

  typedef enum logic {StIdle, StShift} rb_state_e;

  logic [NoConfigBits-1:0] sync_q [SyncStages];
  logic [NoConfigBits-1:0] s;
  logic [NoConfigBits-1:0] s_q;
  logic [NoConfigBits-1:0] c_bits_q, c_bits_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    changed_q;
  logic                    commit;

  rb_state_e               state_q;
  logic [NoConfigBits-1:0] sh_q;
  logic [IdxW-1:0]         idx_q;
  logic                    rb_valid_q;
  logic                    rb_done_q;

  assign s = sync_q[SyncStages-1];

  // Per-bit synchroniser chain into the user clock domain.
  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      for (int k = 0; k < int'(SyncStages); k++) sync_q[k] <= ResetValue;
    end else begin
      sync_q[0] <= ConfigBits;
      for (int k = 1; k < int'(SyncStages); k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // Stability counting and the atomic commit decision.
  always_comb begin
    commit   = (cnt_q == CntMax) && (s_q != c_bits_q) && !C_hold;
    c_bits_d = commit ? s_q : c_bits_q;
    if (s != s_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Sample register, stability counter, committed vector and change pulse.
  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      s_q       <= ResetValue;
      cnt_q     <= '0;
      c_bits_q  <= ResetValue;
      changed_q <= 1'b0;
    end else begin
      s_q       <= s;
      cnt_q     <= cnt_d;
      c_bits_q  <= c_bits_d;
      changed_q <= commit;
    end
  end

  // Readback FSM: snapshot the committed vector, then shift it out LSB first.
  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      state_q    <= StIdle;
      sh_q       <= '0;
      idx_q      <= '0;
      rb_valid_q <= 1'b0;
      rb_done_q  <= 1'b0;
    end else begin
      rb_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (RB_start) begin
            // Register value, so a commit on this same edge is not seen.
            sh_q       <= c_bits_q;
            idx_q      <= '0;
            rb_valid_q <= 1'b1;
            state_q    <= StShift;
          end
        end
        StShift: begin
          sh_q  <= sh_q >> 1;
          idx_q <= idx_q + IdxW'(1);
          if (idx_q == IdxLast) begin
            rb_valid_q <= 1'b0;
            rb_done_q  <= 1'b1;
            state_q    <= StIdle;
          end
        end
      endcase
    end
  end

  assign C_bits    = c_bits_q;
  assign C_changed = changed_q;
  assign RB_valid  = rb_valid_q;
  assign RB_data   = rb_valid_q & sh_q[0];
  assign RB_done   = rb_done_q;

endmodule

// File: tb/tb_config_access_sync.sv
// Bench for config_access_sync: directed scenarios plus a randomized run, all checked every
// cycle against a history-based reference model of the commit and readback behaviour.
module tb_config_access_sync;

  localparam int unsigned N      = 8;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned STABLE = 4;
  localparam logic [N-1:0] RV    = '0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] cfg = '0;
  logic         hold = 1'b0;
  logic         rb_start = 1'b0;
  logic [N-1:0] c_bits;
  logic         c_changed, rb_valid, rb_data, rb_done;

  int n_cmp = 0;
  int n_fail = 0;

  config_access_sync #(
    .NoConfigBits(N),
    .SyncStages  (SYNC),
    .StableCycles(STABLE),
    .ResetValue  (RV)
  ) dut (
    .UserCLK   (clk),
    .Reset     (rst),
    .ConfigBits(cfg),
    .C_hold    (hold),
    .RB_start  (rb_start),
    .C_bits    (c_bits),
    .C_changed (c_changed),
    .RB_valid  (rb_valid),
    .RB_data   (rb_data),
    .RB_done   (rb_done)
  );

  always #5 clk = ~clk;

  // Reference model state.
  // hist[e] is the ConfigBits value sampled at edge e. A value commits at edge t when the
  // samples that have fully crossed the synchroniser were identical for StableCycles+1
  // consecutive samples, all taken after the last reset.
  logic [N-1:0] hist [int];
  int           ec = 0;
  int           rst_edge = 0;
  logic [N-1:0] m_bits = RV;
  logic         m_changed = 1'b0;
  logic         m_done = 1'b0;
  bit           rbq [$];

  wire [N+3:0] dut_vec = {c_bits, c_changed, rb_valid, rb_data, rb_done};

  function automatic logic [N+3:0] exp_vec();
    logic v, d;
    v = (rbq.size() > 0);
    d = v ? rbq[0] : 1'b0;
    return {m_bits, m_changed, v, d, m_done};
  endfunction

  task automatic model_edge();
    logic [N-1:0] cand;
    bit           stable;
    ec++;
    hist[ec] = cfg;
    if (rst) begin
      // Reset flushes the synchroniser pipeline with the reset value.
      for (int k = 0; k <= int'(SYNC); k++) hist[ec-k] = RV;
      rst_edge  = ec;
      m_bits    = RV;
      m_changed = 1'b0;
      m_done    = 1'b0;
      rbq.delete();
    end else begin
      m_done = (rbq.size() == 1);
      if (rbq.size() > 0) begin
        void'(rbq.pop_front());
      end else if (rb_start) begin
        for (int k = 0; k < int'(N); k++) rbq.push_back(m_bits[k]);
      end
      stable = (ec - int'(STABLE) >= rst_edge + 1);
      cand   = '0;
      if (stable) begin
        cand = hist[ec-int'(SYNC)-1];
        for (int j = 0; j <= int'(STABLE); j++)
          if (hist[ec-int'(SYNC)-1-j] !== cand) stable = 0;
      end
      m_changed = stable && (cand != m_bits) && !hold;
      if (m_changed) m_bits = cand;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (c_bits !== 8'h00 || c_changed !== 1'b0 || rb_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state cyc %0d: got bits=%h chg=%b vld=%b, want 00/0/0",
                 c, c_bits, c_changed, rb_valid);
      end
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_model edge %0d: got %h want %h", ec, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_commit_latency();
    int pulses = 0;
    cfg = 8'hA5;
    tick();  // edge E0
    for (int e = 1; e <= 57; e++) begin
      logic [N-1:0] want_bits;
      tick();
      if (c_changed) pulses++;
      if (e <= 7) begin
        want_bits = (e >= 7) ? 8'hA5 : 8'h00;
        n_cmp++;
        if (c_bits !== want_bits || c_changed !== (e == 7)) begin
          n_fail++;
          $display("FAIL commit_latency E0+%0d: got bits=%h chg=%b, want %h/%b",
                   e, c_bits, c_changed, want_bits, (e == 7));
        end
      end
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL commit_model edge %0d: got %h want %h", ec, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL commit_pulse_count: got %0d pulses, want 1", pulses);
    end
  endtask

  task automatic settle(input logic [N-1:0] val);
    cfg = val;
    for (int c = 0; c < 14; c++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL settle_model edge %0d: got %h want %h", ec, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_glitch();
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 8; c++) begin
        cfg = (c < 3) ? 8'h01 : 8'h00;
        tick();
        n_cmp++;
        if (c_bits !== 8'h00 || c_changed !== 1'b0) begin
          n_fail++;
          $display("FAIL glitch rep %0d cyc %0d: got bits=%h chg=%b, want 00/0",
                   r, c, c_bits, c_changed);
        end
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
          n_fail++;
          $display("FAIL glitch_model edge %0d: got %h want %h", ec, dut_vec, exp_vec());
        end
      end
    end
  endtask

  task automatic test_hold();
    hold = 1'b1;
    cfg  = 8'h3C;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_cmp++;
      if (c_bits !== 8'h00 || c_changed !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_block cyc %0d: got bits=%h chg=%b, want 00/0", c, c_bits, c_changed);
      end
    end
    hold = 1'b0;
    tick();
    n_cmp++;
    if (c_bits !== 8'h3C || c_changed !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: got bits=%h chg=%b, want 3c/1", c_bits, c_changed);
    end
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL hold_model edge %0d: got %h want %h", ec, dut_vec, exp_vec());
    end
    tick();
    n_cmp++;
    if (c_changed !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_pulse_width: got chg=%b, want 0", c_changed);
    end
  endtask

  task automatic test_readback();
    logic [N-1:0] pat;
    pat = 8'hA5;
    settle(8'hA5);
    cfg = 8'h3C;  // sampled one edge before RB_start: commit lands mid-stream
    tick();
    rb_start = 1'b1;
    tick();
    rb_start = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      n_cmp++;
      if (rb_valid !== 1'b1 || rb_data !== pat[k] || rb_done !== 1'b0) begin
        n_fail++;
        $display("FAIL readback bit %0d: got vld=%b data=%b done=%b, want 1/%b/0",
                 k, rb_valid, rb_data, rb_done, pat[k]);
      end
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL readback_model edge %0d: got %h want %h", ec, dut_vec, exp_vec());
      end
      if (k == 2) rb_start = 1'b1;
      tick();
      rb_start = 1'b0;
    end
    n_cmp++;
    if (rb_done !== 1'b1 || rb_valid !== 1'b0 || c_bits !== 8'h3C) begin
      n_fail++;
      $display("FAIL readback_done: got done=%b vld=%b bits=%h, want 1/0/3c",
               rb_done, rb_valid, c_bits);
    end
    tick();
    n_cmp++;
    if (rb_done !== 1'b0 || rb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL readback_idle: got done=%b vld=%b, want 0/0", rb_done, rb_valid);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    cfg = 8'h5A;
    rb_start = 1'b1;
    tick();
    rb_start = 1'b0;
    repeat (3) tick();  // now in the 4th readback cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (rb_valid !== 1'b0 || rb_done !== 1'b0 || c_bits !== RV || c_changed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got vld=%b done=%b bits=%h chg=%b, want 0/0/%h/0",
               rb_valid, rb_done, c_bits, c_changed, RV);
    end
    // First edge after release is E0; the held value commits at E0+7.
    for (int e = 0; e < 16; e++) begin
      tick();
      if (rb_done) dones++;
      if (e <= 7) begin
        n_cmp++;
        if (c_bits !== ((e == 7) ? 8'h5A : RV) || c_changed !== (e == 7)) begin
          n_fail++;
          $display("FAIL recommit E0+%0d: got bits=%h chg=%b", e, c_bits, c_changed);
        end
      end
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_mid_model edge %0d: got %h want %h", ec, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL reset_mid_done: got %0d done pulses, want 0", dones);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 11) == 0) cfg = N'($urandom);
      if ($urandom_range(0, 19) == 0) hold = ~hold;
      rb_start = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_model edge %0d: got %h want %h", ec, dut_vec, exp_vec());
      end
    end
    rst      = 1'b0;
    hold     = 1'b0;
    rb_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_commit_latency();
    settle(8'h00);
    test_glitch();
    test_hold();
    test_readback();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
